// File: rtl/seg_display_scheduler_if.sv
// seg_display_scheduler_if: request/data inputs and display outputs of the display scheduler
interface seg_display_scheduler_if;
    logic        tick;
    logic [2:0]  req;
    logic [15:0] data0;
    logic [15:0] data1;
    logic [15:0] data2;
    logic        alert;
    logic [15:0] alert_data;
    logic [15:0] num;
    logic [1:0]  src;
    logic        switched;
    modport master (output tick, req, data0, data1, data2, alert, alert_data, input num, src, switched);
    modport slave  (input tick, req, data0, data1, data2, alert, alert_data, output num, src, switched);
endinterface

// File: rtl/seg_display_scheduler.sv
// seg_display_scheduler: round-robin time-slicing of one 4-digit display with a blinking pre-emptive alert
module seg_display_scheduler #(
    parameter int DWELL_TICKS = 4,
    parameter int BLINK_TICKS = 2,
    parameter int CNT_W       = 4
) (
    input logic clk,
    input logic rst,
    seg_display_scheduler_if.slave bus
);
    localparam logic [1:0] IDLE = 2'd0, SHOW = 2'd1, ALERT_ON = 2'd2, ALERT_OFF = 2'd3;
    localparam logic [15:0] DASHES = 16'hAAAA;
    localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_TICKS - 1);
    localparam logic [CNT_W-1:0] BLINK_LAST = CNT_W'(BLINK_TICKS - 1);

    logic [1:0] state, state_n, owner, owner_n, last, last_n, saved, saved_n, src_n;
    logic [1:0] win_all, win_oth;
    logic [CNT_W-1:0] dwell_cnt, dwell_n, blink_cnt, blink_n;
    logic [2:0] others;
    logic owner_req, saved_req;
    logic [15:0] num_n;

    function automatic logic [1:0] nxt(input logic [1:0] l);
        return (l == 2'd2) ? 2'd0 : l + 2'd1;
    endfunction

    function automatic logic [1:0] rr(input logic [1:0] l, input logic [2:0] m);
        logic [1:0] a, b;
        a = nxt(l);
        b = nxt(a);
        return m[a] ? a : m[b] ? b : nxt(b);
    endfunction

    function automatic logic [1:0] cls(input logic [1:0] s);
        return s[1] ? 2'd2 : s;
    endfunction

    // Shifting by 3 yields zero, so "none" never matches a request bit
    assign owner_req = |(bus.req & (3'b001 << owner));
    assign saved_req = |(bus.req & (3'b001 << saved));
    assign others    = bus.req & ~(3'b001 << owner);
    assign win_all   = rr(last, bus.req);
    assign win_oth   = rr(last, others);

    always_comb begin
        state_n = state;
        owner_n = owner;
        last_n  = last;
        saved_n = saved;
        dwell_n = dwell_cnt;
        blink_n = blink_cnt;
        if (!state[1]) begin
            if (bus.alert) begin
                state_n = ALERT_ON;
                blink_n = '0;
                saved_n = (state == SHOW) ? owner : 2'd3;
            end else if (state == IDLE || !owner_req) begin
                state_n = |bus.req ? SHOW : IDLE;
                owner_n = win_all;
                last_n  = |bus.req ? win_all : last;
                dwell_n = '0;
            end else if (bus.tick) begin
                if (dwell_cnt != DWELL_LAST) begin
                    dwell_n = dwell_cnt + 1'b1;
                end else if (|others) begin
                    owner_n = win_oth;
                    last_n  = win_oth;
                    dwell_n = '0;
                end
            end
        end else if (!bus.alert) begin
            state_n = (saved_req || |bus.req) ? SHOW : IDLE;
            owner_n = saved_req ? saved : win_all;
            last_n  = saved_req ? saved : |bus.req ? win_all : last;
            dwell_n = '0;
        end else if (bus.tick) begin
            // Phase flips after BLINK_TICKS ticks in either alert state
            state_n = (blink_cnt == BLINK_LAST) ? (state == ALERT_ON ? ALERT_OFF : ALERT_ON) : state;
            blink_n = (blink_cnt == BLINK_LAST) ? '0 : blink_cnt + 1'b1;
        end
        src_n = (state_n == SHOW) ? owner_n : 2'd3;
        num_n = (state_n == ALERT_ON) ? bus.alert_data :
                (state_n != SHOW)     ? DASHES :
                (owner_n == 2'd0)     ? bus.data0 :
                (owner_n == 2'd1)     ? bus.data1 : bus.data2;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state        <= IDLE;
            owner        <= 2'd0;
            last         <= 2'd2;
            saved        <= 2'd3;
            dwell_cnt    <= '0;
            blink_cnt    <= '0;
            bus.num      <= DASHES;
            bus.src      <= 2'd3;
            bus.switched <= 1'b0;
        end else begin
            state        <= state_n;
            owner        <= owner_n;
            last         <= last_n;
            saved        <= saved_n;
            dwell_cnt    <= dwell_n;
            blink_cnt    <= blink_n;
            bus.num      <= num_n;
            bus.src      <= src_n;
            bus.switched <= (src_n != bus.src) || (cls(state_n) != cls(state));
        end
    end
endmodule

// File: tb/tb_seg_display_scheduler.sv
// tb_seg_display_scheduler: directed scenario checks of the display scheduler
module tb_seg_display_scheduler;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int checks = 0;
    int errors = 0;
    int sw_cnt = 0;

    seg_display_scheduler_if bus();

    seg_display_scheduler #(.DWELL_TICKS(4), .BLINK_TICKS(2), .CNT_W(4)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
        if (bus.switched) sw_cnt++;
    endtask

    task automatic tick_pulse();
        bus.tick = 1'b1;
        step();
        bus.tick = 1'b0;
        step();
    endtask

    task automatic do_reset();
        bus.req = 3'b000;
        bus.alert = 1'b0;
        bus.tick = 1'b0;
        rst = 1'b0;
        step();
        rst = 1'b1;
    endtask

    task automatic chk_src(input string name, input logic [1:0] exp);
        checks++;
        if (bus.src !== exp) begin errors++; $display("FAIL %s src got=%0d exp=%0d", name, bus.src, exp); end
    endtask

    task automatic chk_num(input string name, input logic [15:0] exp);
        checks++;
        if (bus.num !== exp) begin errors++; $display("FAIL %s num got=%h exp=%h", name, bus.num, exp); end
    endtask

    task automatic chk_sw(input string name, input logic exp);
        checks++;
        if (bus.switched !== exp) begin errors++; $display("FAIL %s switched got=%b exp=%b", name, bus.switched, exp); end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        bus.req = 3'b111;
        bus.alert = 1'b1;
        bus.tick = 1'b1;
        step();
        bus.tick = 1'b0;
        step();
        chk_num("reset", 16'hAAAA);
        chk_src("reset", 2'd3);
        chk_sw("reset", 1'b0);
        rst = 1'b1;
        bus.alert = 1'b0;
        step();
        chk_src("release", 2'd0);
        chk_sw("release", 1'b1);
        chk_num("release", 16'h1234);
        step();
        chk_sw("release_next", 1'b0);
    endtask

    task automatic test_round_robin();
        do_reset();
        bus.req = 3'b101;
        step();
        chk_src("rr_start", 2'd0);
        for (int k = 1; k <= 3; k++) begin
            tick_pulse();
            chk_src("rr_dwell0", 2'd0);
        end
        tick_pulse();
        chk_src("rr_to2", 2'd2);
        chk_num("rr_to2", 16'h0059);
        for (int k = 1; k <= 3; k++) begin
            tick_pulse();
            chk_src("rr_dwell2", 2'd2);
        end
        tick_pulse();
        chk_src("rr_back0", 2'd0);
        chk_num("rr_back0", 16'h1234);
        bus.data0 = 16'h4321;
        chk_num("latency_before", 16'h1234);
        step();
        chk_num("latency_after", 16'h4321);
        bus.data0 = 16'h1234;
        step();
    endtask

    task automatic test_single();
        do_reset();
        bus.req = 3'b010;
        step();
        chk_src("single_start", 2'd1);
        sw_cnt = 0;
        for (int k = 0; k < 10; k++) tick_pulse();
        chk_src("single_hold", 2'd1);
        checks++;
        if (sw_cnt !== 0) begin errors++; $display("FAIL single_no_switch pulses got=%0d exp=0", sw_cnt); end
        bus.req = 3'b011;
        step();
        chk_src("single_competitor", 2'd1);
        tick_pulse();
        chk_src("single_handoff", 2'd0);
        checks++;
        if (sw_cnt !== 1) begin errors++; $display("FAIL single_handoff pulses got=%0d exp=1", sw_cnt); end
    endtask

    task automatic test_owner_drop();
        do_reset();
        bus.req = 3'b100;
        step();
        chk_src("drop_start", 2'd2);
        bus.req = 3'b101;
        tick_pulse();
        tick_pulse();
        chk_src("drop_keep", 2'd2);
        bus.req = 3'b001;
        step();
        chk_src("drop_to0", 2'd0);
        bus.req = 3'b011;
        for (int k = 1; k <= 3; k++) tick_pulse();
        chk_src("drop_dwell_restart", 2'd0);
        tick_pulse();
        chk_src("drop_dwell_end", 2'd1);
        bus.req = 3'b000;
        step();
        chk_src("drop_idle", 2'd3);
        chk_num("drop_idle", 16'hAAAA);
        chk_sw("drop_idle", 1'b1);
    endtask

    task automatic test_alert();
        do_reset();
        bus.alert_data = 16'h9999;
        bus.req = 3'b010;
        step();
        tick_pulse();
        tick_pulse();
        bus.alert = 1'b1;
        step();
        chk_src("alert_enter", 2'd3);
        chk_num("alert_enter", 16'h9999);
        sw_cnt = 0;
        tick_pulse();
        chk_num("alert_on1", 16'h9999);
        tick_pulse();
        chk_num("alert_off", 16'hAAAA);
        chk_src("alert_off", 2'd3);
        tick_pulse();
        chk_num("alert_off1", 16'hAAAA);
        tick_pulse();
        chk_num("alert_on_again", 16'h9999);
        checks++;
        if (sw_cnt !== 0) begin errors++; $display("FAIL alert_toggle pulses got=%0d exp=0", sw_cnt); end
        bus.alert_data = 16'h8888;
        chk_num("alert_live_before", 16'h9999);
        step();
        chk_num("alert_live_after", 16'h8888);
        bus.alert = 1'b0;
        step();
        chk_src("alert_exit", 2'd1);
        chk_num("alert_exit", 16'h5678);
        bus.req = 3'b011;
        for (int k = 1; k <= 3; k++) tick_pulse();
        chk_src("alert_dwell_restart", 2'd1);
        tick_pulse();
        chk_src("alert_dwell_end", 2'd0);
    endtask

    task automatic test_simultaneous();
        do_reset();
        bus.alert_data = 16'h9999;
        bus.req = 3'b101;
        step();
        chk_src("sim_start", 2'd0);
        bus.tick = 1'b1;
        bus.req = 3'b100;
        bus.alert = 1'b1;
        step();
        bus.tick = 1'b0;
        chk_src("sim_alert", 2'd3);
        chk_num("sim_alert", 16'h9999);
        bus.alert = 1'b0;
        step();
        chk_src("sim_rr_winner", 2'd2);
        chk_num("sim_rr_winner", 16'h0059);
    endtask

    task automatic test_reset_mid();
        bus.req = 3'b111;
        bus.alert = 1'b1;
        bus.tick = 1'b1;
        rst = 1'b0;
        step();
        chk_src("midreset", 2'd3);
        chk_num("midreset", 16'hAAAA);
        chk_sw("midreset", 1'b0);
        rst = 1'b1;
        bus.alert = 1'b0;
        bus.tick = 1'b0;
        step();
        chk_src("midreset_release", 2'd0);
    endtask

    initial begin
        bus.tick = 1'b0;
        bus.req = 3'b000;
        bus.alert = 1'b0;
        bus.data0 = 16'h1234;
        bus.data1 = 16'h5678;
        bus.data2 = 16'h0059;
        bus.alert_data = 16'h9999;
        test_reset();
        test_round_robin();
        test_single();
        test_owner_drop();
        test_alert();
        test_simultaneous();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/seg_display_scheduler.md
Name: seg_display_scheduler

Overview:
- Shares the single 16-bit, 4-digit seven-segment display value between three requesting sources (e.g. score, timer, status) plus one priority alert source.
- Requesters are time-sliced round-robin, with a dwell time counted in slow tick strobes.
- An asserted alert pre-empts all requesters and blinks.
- The output drives the display driver's 16-bit num input. Nibble 4'hA renders as '-', so 16'hAAAA is the "dashes/blank" pattern.

Parameters:
- DWELL_TICKS, 4: ticks a requester keeps the display while others are waiting (>=1).
- BLINK_TICKS, 2: ticks per alert on-phase and per alert off-phase (>=1).
- CNT_W, 4: width of the tick counters. Must hold max(DWELL_TICKS, BLINK_TICKS).

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  synchronous, active-low reset (0 = reset, sampled on posedge clk).
- tick  in  1  one-clk-wide timebase strobe (e.g. ~0.5 s); ignored while rst=0.
- req  in  3  per-source display request, level; bit i = source i.
- data0  in  16  source 0 value, 4 BCD/code nibbles.
- data1  in  16  source 1 value.
- data2  in  16  source 2 value.
- alert  in  1  priority alert request, level.
- alert_data  in  16  alert value.
- num  out  16  registered value to the seven-segment driver.
- src  out  2  registered current owner: 0-2 = source, 2'd3 = none or alert.
- switched  out  1  one-clk pulse when src or the state class changes.

Behaviour:
- Reset (rst=0 at posedge):
  - state=IDLE, num=16'hAAAA, src=2'd3, switched=0.
  - Round-robin pointer last=2, so the first search starts at source 0.
  - dwell_cnt=0, blink_cnt=0, saved owner=3.
- Round-robin search: starting at (last+1) mod 3, the first i with req[i]=1.
- States:
  - IDLE: num=16'hAAAA, src=3; ticks ignored. If any req, go to SHOW with owner = RR winner, dwell_cnt=0, last=owner.
  - SHOW: num <= data[owner] every clk (1-clk latency from data change to num; data is not latched). dwell_cnt increments on tick.
    - Tick with dwell_cnt==DWELL_TICKS-1: if another req bit (not owner) is set, go to the RR winner and clear dwell_cnt. Otherwise stay with dwell_cnt held at DWELL_TICKS-1, so the hand-off happens on the next tick after a competitor appears.
    - req[owner] drops: next clk goes to the RR winner among remaining requesters (dwell_cnt=0), or to IDLE if none.
  - ALERT_ON: num=alert_data (live, 1-clk latency), src=3. blink_cnt counts ticks; at BLINK_TICKS-1, go to ALERT_OFF and clear blink_cnt.
  - ALERT_OFF: num=16'hAAAA, src=3. Same count, then back to ALERT_ON.
- Alert pre-emption:
  - alert=1 in IDLE or SHOW: next clk enters ALERT_ON with blink_cnt=0. The current owner is saved (3 if IDLE) and dwell_cnt is held.
  - alert=0 in either alert state: next clk returns to SHOW with the saved owner and dwell_cnt=0 if req[saved] is still 1. Otherwise go to the RR winner, or IDLE if none.
- Simultaneous-event priority:
  - Order: reset > alert > owner req drop > tick.
  - Tick in the same clk as a state change is consumed by the change; counters clear, not increment.
- switched = 1 for exactly the clk in which the registered src or state class (idle/show/alert) takes a new value. It is not asserted for an ALERT_ON/ALERT_OFF toggle.
- Reset asserted mid-operation: all registers return to reset values on that posedge, regardless of tick, alert or req.
- Sub-clk req glitches are not filtered; a one-clk req drop releases ownership.

Test Plan:
- Reset: rst=0 for 2 clks with req=3'b111 and alert=1 -> num=16'hAAAA, src=3, switched=0. On release with req=3'b111, alert=0 -> src=0 one clk later, switched pulses once.
- Round-robin dwell: req=3'b101, DWELL_TICKS=4 -> src=0 for exactly 4 ticks, then src=2 for 4 ticks, then src=0. num tracks data0=16'h1234 / data2=16'h0059 with 1-clk latency.
- Single requester: req=3'b010 for 10 ticks -> src=1 throughout, no switched pulse. Raise req[0] -> src becomes 0 on the next tick.
- Owner drop: src=2, drop req[2] while req[0]=1 -> src=0 next clk, dwell restarts. Drop all req -> IDLE, num=16'hAAAA.
- Alert pre-emption: in SHOW src=1, dwell_cnt=2, assert alert with alert_data=16'h9999, BLINK_TICKS=2 -> num alternates 16'h9999 / 16'hAAAA every 2 ticks with src=3. On deassert -> src=1, dwell restarts at 0.
- Simultaneous events: tick, owner req drop and alert rise in the same clk -> enters ALERT_ON. Saved owner is not re-shown after the alert if its req=0; the RR winner is shown instead.
